stream_fifo_rl1: RTL and testbench

Parametrised Avalon-ST packet buffer with ready latency 1 on both sink and source. It generalises the single-entry EOP stream register to a DEPTH-entry FIFO carrying SOP/EOP sideband, with an optional store-and-forward packet mode. It sits between camera-pipeline filter stages, for example pixel path into EOP-delimited frame consumers, wherever more than one beat of elasticity is needed.

---
 rtl/stream_pkg.sv | 11 +
 rtl/stream_fifo_mem.sv | 44 ++++
 rtl/stream_fifo_rl1.sv | 89 ++++++++
 tb/tb_stream_fifo_rl1.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared definitions for the ready-latency-1 streaming blocks.
package stream_pkg;

    localparam int READY_LATENCY = 1;

    // Width able to hold an occupancy count 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// DEPTH-entry beat storage: one write port, combinational read of the head,
// pointers wrapping modulo DEPTH (DEPTH need not be a power of two).
module stream_fifo_mem
    import stream_pkg::*;
#(
    parameter int WIDTH = 26,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_beat,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_beat
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= bump(wr_ptr);
            if (rd_en) rd_ptr <= bump(rd_ptr);
        end
    end

    // Storage is deliberately left out of reset; the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_beat;
    end

    assign rd_beat = mem[rd_ptr];

endmodule

// File: rtl/stream_fifo_rl1.sv
// Avalon-ST packet FIFO, ready latency 1 on both sides, with optional
// store-and-forward release gating.
module stream_fifo_rl1
    import stream_pkg::*;
#(
    parameter int DATA_WIDTH  = 24,
    parameter int DEPTH       = 4,
    parameter int PACKET_MODE = 0,
    parameter int LW          = level_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  snk_valid,
    input  logic [DATA_WIDTH-1:0] snk_data,
    input  logic                  snk_sop,
    input  logic                  snk_eop,
    output logic                  snk_ready,
    input  logic                  src_ready,
    output logic                  src_valid,
    output logic [DATA_WIDTH-1:0] src_data,
    output logic                  src_sop,
    output logic                  src_eop,
    output logic [LW-1:0]         level,
    output logic [LW-1:0]         pkt_count
);

    typedef struct packed {
        logic                  sop;
        logic                  eop;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    beat_t         wr_beat;
    beat_t         head;
    logic          snk_ready_d;
    logic          src_ready_d;
    logic          wr;
    logic          rd;
    logic          release_ok;
    logic [LW-1:0] level_nxt;
    logic [LW-1:0] pkt_nxt;

    assign wr_beat = '{sop: snk_sop, eop: snk_eop, data: snk_data};
    assign wr      = snk_valid & snk_ready_d;

    // Store-and-forward waits for a complete packet, unless the FIFO is full:
    // a packet longer than DEPTH would otherwise never be released.
    assign release_ok = (PACKET_MODE == 0) || (pkt_count != '0) || (level == LW'(DEPTH));
    assign src_valid  = src_ready_d & (level != '0) & release_ok;
    assign rd         = src_valid;

    assign level_nxt = level + LW'(wr) - LW'(rd);
    assign pkt_nxt   = pkt_count + LW'(wr & snk_eop) - LW'(rd & head.eop);

    always_ff @(posedge clk) begin
        if (rst) begin
            snk_ready   <= 1'b0;
            snk_ready_d <= 1'b0;
            src_ready_d <= 1'b0;
            level       <= '0;
            pkt_count   <= '0;
        end else begin
            // Counting the grant already in flight keeps a free slot for it
            // regardless of what the read side does.
            snk_ready   <= ({1'b0, level_nxt} + (LW + 1)'(snk_ready)) <= (LW + 1)'(DEPTH - 1);
            snk_ready_d <= snk_ready;
            src_ready_d <= src_ready;
            level       <= level_nxt;
            pkt_count   <= pkt_nxt;
        end
    end

    stream_fifo_mem #(
        .WIDTH ($bits(beat_t)),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr),
        .wr_beat (wr_beat),
        .rd_en   (rd),
        .rd_beat (head)
    );

    assign src_data = head.data;
    assign src_sop  = head.sop;
    assign src_eop  = head.eop;

endmodule

// File: tb/tb_stream_fifo_rl1.sv
// Randomised bench for stream_fifo_rl1 (cut-through and store-and-forward
// instances) against a queue-based reference model.
module tb_stream_fifo_rl1;

    localparam int DW    = 24;
    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          snk_valid, snk_sop, snk_eop, src_ready;
    logic [DW-1:0] snk_data;

    logic          a_snk_ready, a_src_valid, a_src_sop, a_src_eop;
    logic [DW-1:0] a_src_data;
    logic [LW-1:0] a_level, a_pkt_count;
    logic          b_snk_ready, b_src_valid, b_src_sop, b_src_eop;
    logic [DW-1:0] b_src_data;
    logic [LW-1:0] b_level, b_pkt_count;

    always #5 clk = ~clk;

    stream_fifo_rl1 #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PACKET_MODE(0)) u_ct (
        .clk(clk), .rst(rst),
        .snk_valid(snk_valid), .snk_data(snk_data), .snk_sop(snk_sop), .snk_eop(snk_eop),
        .snk_ready(a_snk_ready), .src_ready(src_ready), .src_valid(a_src_valid),
        .src_data(a_src_data), .src_sop(a_src_sop), .src_eop(a_src_eop),
        .level(a_level), .pkt_count(a_pkt_count)
    );

    stream_fifo_rl1 #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PACKET_MODE(1)) u_pm (
        .clk(clk), .rst(rst),
        .snk_valid(snk_valid), .snk_data(snk_data), .snk_sop(snk_sop), .snk_eop(snk_eop),
        .snk_ready(b_snk_ready), .src_ready(src_ready), .src_valid(b_src_valid),
        .src_data(b_src_data), .src_sop(b_src_sop), .src_eop(b_src_eop),
        .level(b_level), .pkt_count(b_pkt_count)
    );

    // Both instances see the same stimulus; 'mode' picks the one under check.
    bit            mode;
    logic          o_rdy, o_valid, o_sop, o_eop;
    logic [DW-1:0] o_data;
    logic [LW-1:0] o_level, o_pkt;

    always_comb begin
        o_rdy   = mode ? b_snk_ready : a_snk_ready;
        o_valid = mode ? b_src_valid : a_src_valid;
        o_sop   = mode ? b_src_sop   : a_src_sop;
        o_eop   = mode ? b_src_eop   : a_src_eop;
        o_data  = mode ? b_src_data  : a_src_data;
        o_level = mode ? b_level     : a_level;
        o_pkt   = mode ? b_pkt_count : a_pkt_count;
    end

    // Reference model: contents as a queue of {sop, eop, data}.
    logic [DW+1:0] q[$];
    bit  m_rdy, m_rdy_d, m_srd;
    bit  last_wr, last_rd;
    int  n_chk, n_err;
    int  lvl_max, pkt_max;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int eop_cnt();
        int n = 0;
        foreach (q[i]) if (q[i][DW]) n++;
        return n;
    endfunction

    task automatic new_beat();
        snk_data = DW'($urandom);
        snk_sop  = 1'($urandom_range(0, 1));
        snk_eop  = ($urandom_range(0, 3) == 0);
    endtask

    // One clock: check outputs mid-cycle, advance the model, step past the edge.
    task automatic cyc();
        bit            ev, nr;
        logic [DW+1:0] hd;
        @(negedge clk);
        ev = m_srd && (q.size() > 0) && (!mode || eop_cnt() > 0 || q.size() == DEPTH);
        chk("src_valid", o_valid, ev);
        chk("level", o_level, q.size());
        chk("pkt_count", o_pkt, eop_cnt());
        chk("snk_ready", o_rdy, m_rdy);
        if (int'(o_level) > lvl_max) lvl_max = o_level;
        if (int'(o_pkt) > pkt_max) pkt_max = o_pkt;
        if (ev) begin
            hd = q.pop_front();
            chk("head", {o_sop, o_eop, o_data}, hd);
        end
        last_rd = ev;
        last_wr = snk_valid && m_rdy_d;
        if (last_wr) q.push_back({snk_sop, snk_eop, snk_data});
        nr      = (q.size() + int'(m_rdy)) <= DEPTH - 1;
        m_rdy_d = m_rdy;
        m_rdy   = nr;
        m_srd   = src_ready;
        if (rst) begin
            q.delete();
            m_rdy = 0; m_rdy_d = 0; m_srd = 0; last_wr = 0; last_rd = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc, pops, first_v, eop_c;
        mode = 0; rst = 1; snk_valid = 0; snk_sop = 0; snk_eop = 0; snk_data = '0; src_ready = 0;
        m_rdy = 0; m_rdy_d = 0; m_srd = 0; n_chk = 0; n_err = 0; lvl_max = 0; pkt_max = 0;
        @(posedge clk);
        #1;
        cyc(); cyc();
        rst = 0;

        // Fill with src_ready low: exactly DEPTH beats get in.
        snk_valid = 1; snk_data = 1; snk_sop = 1; snk_eop = 0; acc = 0;
        repeat (10) begin
            cyc();
            if (last_wr) begin
                acc++; snk_data++; snk_sop = 0; snk_eop = (snk_data == 4);
            end
        end
        snk_valid = 0;
        chk("fill_acc", acc, 4);
        chk("fill_level", a_level, 4);

        // Drain in order.
        src_ready = 1; pops = 0;
        repeat (8) begin cyc(); if (last_rd) pops++; end
        chk("drain_pops", pops, 4);
        chk("drain_level", a_level, 0);
        chk("drain_ready", a_snk_ready, 1);

        // Streaming at full rate.
        snk_valid = 1; new_beat(); lvl_max = 0; pops = 0;
        for (int i = 0; i < 110; i++) begin
            cyc();
            if (i >= 10 && last_rd) pops++;
            if (last_wr) new_beat();
        end
        chk("stream_level_max", (lvl_max <= 2), 1);
        chk("stream_tput", pops, 100);

        // Random traffic, including ungranted beats.
        for (int i = 0; i < 300; i++) begin
            snk_valid = 1'($urandom_range(0, 1));
            src_ready = ($urandom_range(0, 3) != 0);
            new_beat();
            cyc();
        end

        // Reset with three beats held.
        snk_valid = 0; src_ready = 1;
        repeat (8) cyc();
        src_ready = 0; snk_valid = 1; acc = 0;
        for (int i = 0; i < 12 && acc < 3; i++) begin
            cyc();
            if (last_wr) begin acc++; new_beat(); end
        end
        snk_valid = 0;
        chk("pre_rst_level", a_level, 3);
        rst = 1; cyc(); rst = 0;
        chk("rst_level", a_level, 0);
        chk("rst_pkt", a_pkt_count, 0);
        chk("rst_valid", a_src_valid, 0);
        snk_valid = 1; new_beat(); cyc();
        snk_valid = 0; cyc();
        chk("rst_beat_ignored", a_level, 0);

        // Store-and-forward instance.
        mode = 1; rst = 1; cyc(); rst = 0;
        src_ready = 1; cyc(); cyc();

        // 3-beat packet: release only after the EOP write.
        snk_valid = 1; snk_data = 24'h000011; snk_sop = 1; snk_eop = 0;
        acc = 0; first_v = -1; eop_c = -1; pkt_max = 0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (last_rd && first_v < 0) first_v = c;
            if (last_wr) begin
                acc++;
                if (acc == 3) begin eop_c = c; snk_valid = 0; end
                else begin snk_data++; snk_sop = 0; snk_eop = (acc == 2); end
            end
        end
        chk("pm_release", first_v, eop_c + 1);
        chk("pm_pkt_max", pkt_max, 1);
        chk("pm_pkt_end", b_pkt_count, 0);

        // 6-beat packet longer than DEPTH: full escape must release it.
        snk_valid = 1; snk_data = 24'h000021; snk_sop = 1; snk_eop = 0;
        acc = 0; pops = 0; lvl_max = 0;
        for (int c = 0; c < 40; c++) begin
            cyc();
            if (last_rd) pops++;
            if (last_wr) begin
                acc++;
                if (acc == 6) snk_valid = 0;
                else begin snk_data++; snk_sop = 0; snk_eop = (acc == 5); end
            end
        end
        chk("pm_long_pops", pops, 6);
        chk("pm_long_full", lvl_max, 4);
        chk("pm_long_level", b_level, 0);

        for (int i = 0; i < 300; i++) begin
            snk_valid = 1'($urandom_range(0, 1));
            src_ready = ($urandom_range(0, 3) != 0);
            new_beat();
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
